commit_trace_queue: RTL and testbench
=====================================

Name: commit_trace_queue

Overview:
Multi-lane commit-trace buffer between the core's debug commit outputs and the simulator-side trace consumer. Accepts up to NC commits per cycle, compacts valid lanes into program order, and buffers them in a circular FIFO. Drains them one per cycle over a valid/ready port, each entry tagged with a wrapping sequence number. Generalises the single-lane commit/pc/wnum/wdata trace to N lanes, adds backpressure (stall to core) and sticky overflow detection.

Parameters:
NC, 2, commit lanes per cycle (1..4)
DEPTH, 16, FIFO entries; power of two, DEPTH >= 2*NC
XLEN, 64, pc/wdata width
SEQW, 32, sequence-number width

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_commit  in  NC  per-lane commit valid; lane 0 oldest
in_pc  in  NC*XLEN  per-lane pc, lane i at [i*XLEN +: XLEN]
in_wnum  in  NC*5  per-lane destination register number
in_wdata  in  NC*XLEN  per-lane writeback data
core_stall  out  1  free entries < NC; core must not present commits
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_pc  out  XLEN  head pc
out_wnum  out  5  head wnum
out_wdata  out  XLEN  head wdata (0 when wnum==0)
out_seq  out  SEQW  head sequence number
level  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky: a commit group was dropped

Behaviour:
- Reset (async assert, sync release): rd/wr pointers 0, level 0, next-seq 0, overflow 0; out_valid 0, core_stall 0. out_pc/out_wnum/out_wdata/out_seq read 0 while empty.
- Enqueue count k = popcount(in_commit). Valid lanes compacted in ascending lane order; gaps allowed (e.g. 4'b1010 writes lane1 then lane3).
- Entry j of the group written at wr_ptr+j (mod DEPTH), seq = next_seq+j; wr_ptr += k, next_seq += k. All pointer/seq arithmetic wraps naturally at its width.
- Written wdata forced to 0 when wnum==0.
- Admission check uses free = DEPTH - level at start of cycle; a same-cycle dequeue is NOT credited.
- If k > free: whole group dropped (none written, next_seq unchanged), overflow set; cleared only by reset.
- Dequeue when out_valid && out_ready: rd_ptr += 1.
- level_next = level + k_accepted - deq. Simultaneous enqueue and dequeue both take effect.
- core_stall = (DEPTH - level) < NC, combinational from registered level.
- Latency: entry enqueued at edge t is visible on out_* from t (after edge), i.e. earliest dequeue at edge t+1. No write-to-read bypass; an empty queue shows out_valid=0 in the cycle commits are presented.
- out_* are a registered/array read of rd_ptr. They are stable while out_valid && !out_ready.
- in_commit == 0: no state change except dequeue.
- Reset mid-operation discards all contents immediately.

Decomposition:
- Package trace_pkg: trace_entry_t struct {pc[XLEN], wnum[5], wdata[XLEN], seq[SEQW]}, WNUM_W=5 constant, popcount and prefix-count functions.
- Sub-module commit_compactor: combinational. Maps NC lanes to NC packed slots plus count k via prefix popcount. The top holds storage, pointers, level, seq and flags.

Test Plan:
- Reset, then NC=2: in_commit=2'b11, pc0=0x80000000, pc1=0x80000004, out_ready=1 -> next cycle out_pc=0x80000000 seq=0; following cycle 0x80000004 seq=1; level 2->1->0.
- Gap compaction: in_commit=2'b10, wnum1=5, wdata1=0xDEAD -> one entry, out_wnum=5, out_wdata=0xDEAD, seq=0; level=1.
- x0 filtering: lane0 wnum=0, wdata=0x1234 -> out_wdata=0.
- Backpressure: out_ready=0, fill with 2/cycle, DEPTH=16 -> core_stall rises when level=15 (after 7 groups level=14 no stall, 8th group -> 16, stall=1); out_pc held constant throughout.
- Overflow: level=15, ignore stall, drive 2'b11 with out_ready=1 -> group dropped, overflow=1 sticky, level=14 after dequeue, next accepted seq continues from 15.
- Wrap: SEQW=4, stream 40 single commits -> seq sequence 0..15,0..15,0..7, pointers wrap without loss; async reset_n low mid-stream -> out_valid=0, level=0 immediately.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and lane-counting helpers for the multi-lane commit trace queue.
// Entries are stored at maximum width; the queue truncates to its configured XLEN/SEQW.
package trace_pkg;
  localparam int WNUM_W   = 5;
  localparam int LANE_MAX = 4;
  localparam int CNT_W    = 3;
  localparam int XLEN_MAX = 64;
  localparam int SEQW_MAX = 32;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [WNUM_W-1:0]   wnum;
    logic [XLEN_MAX-1:0] wdata;
    logic [SEQW_MAX-1:0] seq;
  } trace_entry_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [LANE_MAX-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < LANE_MAX; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Number of set lanes strictly below idx: the packed slot that lane idx lands in.
  function automatic int prefix_count(input logic [LANE_MAX-1:0] v, input int idx);
    int c;
    c = 0;
    for (int i = 0; i < LANE_MAX; i++) begin
      if (i < idx) c = c + 32'(v[i]);
    end
    return c;
  endfunction
endpackage

// File: rtl/commit_trace_queue_if.sv
// Commit-side and consumer-side signals of the trace queue; the queue takes the slave view.
// Commits have no ready (core_stall is advisory); the drain side is valid/ready.
interface commit_trace_queue_if
  import trace_pkg::*;
#(
  parameter int NC   = 2,
  parameter int XLEN = 64,
  parameter int SEQW = 32,
  parameter int LW   = 5
);
  logic [NC-1:0]        in_commit;
  logic [NC*XLEN-1:0]   in_pc;
  logic [NC*WNUM_W-1:0] in_wnum;
  logic [NC*XLEN-1:0]   in_wdata;
  logic                 core_stall;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [WNUM_W-1:0]    out_wnum;
  logic [XLEN-1:0]      out_wdata;
  logic [SEQW-1:0]      out_seq;
  logic [LW-1:0]        level;
  logic                 overflow;

  modport master (
    output in_commit, in_pc, in_wnum, in_wdata, out_ready,
    input  core_stall, out_valid, out_pc, out_wnum, out_wdata, out_seq, level, overflow
  );

  modport slave (
    input  in_commit, in_pc, in_wnum, in_wdata, out_ready,
    output core_stall, out_valid, out_pc, out_wnum, out_wdata, out_seq, level, overflow
  );
endinterface

// File: rtl/commit_trace_queue_compactor.sv
// Combinational lane compactor: packs valid commit lanes into slots 0..k-1 in lane order.
// Zero latency, no backpressure; writes to x0 carry zero data.
module commit_compactor
  import trace_pkg::*;
#(
  parameter int NC   = 2,
  parameter int XLEN = 64
) (
  input  logic [NC-1:0]        i_commit,
  input  logic [NC*XLEN-1:0]   i_pc,
  input  logic [NC*WNUM_W-1:0] i_wnum,
  input  logic [NC*XLEN-1:0]   i_wdata,
  output logic [NC*XLEN-1:0]   o_pc,
  output logic [NC*WNUM_W-1:0] o_wnum,
  output logic [NC*XLEN-1:0]   o_wdata,
  output logic [CNT_W-1:0]     o_count
);
  logic [LANE_MAX-1:0] w_lanes;
  int                  w_pos;

  always_comb begin
    w_lanes = LANE_MAX'(i_commit);
    w_pos   = 0;
    o_pc    = '0;
    o_wnum  = '0;
    o_wdata = '0;
    o_count = popcount(w_lanes);
    for (int i = 0; i < NC; i++) begin
      if (i_commit[i]) begin
        w_pos = prefix_count(w_lanes, i);
        o_pc[w_pos*XLEN +: XLEN]       = i_pc[i*XLEN +: XLEN];
        o_wnum[w_pos*WNUM_W +: WNUM_W] = i_wnum[i*WNUM_W +: WNUM_W];
        if (i_wnum[i*WNUM_W +: WNUM_W] != '0) begin
          o_wdata[w_pos*XLEN +: XLEN] = i_wdata[i*XLEN +: XLEN];
        end
      end
    end
  end
endmodule

// File: rtl/commit_trace_queue.sv
// Multi-lane commit trace FIFO: compacted commit groups in, one sequenced entry out per cycle.
// Entry visible the cycle after it is written; groups that do not fit are dropped and flagged sticky.
module commit_trace_queue
  import trace_pkg::*;
#(
  parameter  int NC    = 2,
  parameter  int DEPTH = 16,
  parameter  int XLEN  = 64,
  parameter  int SEQW  = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int LW    = PW + 1
) (
  input  logic            clock,
  input  logic            reset_n,
  commit_trace_queue_if.slave bus
);
  logic [NC*XLEN-1:0]   w_slot_pc;
  logic [NC*WNUM_W-1:0] w_slot_wnum;
  logic [NC*XLEN-1:0]   w_slot_wdata;
  logic [CNT_W-1:0]     w_k;

  trace_entry_t         r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [SEQW-1:0]      r_next_seq;
  logic                 r_overflow;

  logic [LW-1:0]        w_free;
  logic [LW-1:0]        w_k_lw;
  logic [LW-1:0]        w_k_acc;
  logic                 w_accept;
  logic                 w_drop;
  logic                 w_valid;
  logic                 w_deq;
  trace_entry_t         w_ent [NC];
  trace_entry_t         w_head;

  commit_compactor #(
    .NC   (NC),
    .XLEN (XLEN)
  ) u_compactor (
    .i_commit (bus.in_commit),
    .i_pc     (bus.in_pc),
    .i_wnum   (bus.in_wnum),
    .i_wdata  (bus.in_wdata),
    .o_pc     (w_slot_pc),
    .o_wnum   (w_slot_wnum),
    .o_wdata  (w_slot_wdata),
    .o_count  (w_k)
  );

  // Admission sees only the start-of-cycle level; a concurrent dequeue frees nothing yet.
  always_comb begin
    w_free   = LW'(DEPTH) - r_level;
    w_k_lw   = LW'(w_k);
    w_accept = (w_k != '0) && (w_k_lw <= w_free);
    w_drop   = (w_k_lw > w_free);
    w_k_acc  = w_accept ? w_k_lw : '0;
    w_valid  = (r_level != '0);
    w_deq    = w_valid && bus.out_ready;
  end

  always_comb begin
    for (int j = 0; j < NC; j++) begin
      w_ent[j].pc    = XLEN_MAX'(w_slot_pc[j*XLEN +: XLEN]);
      w_ent[j].wnum  = w_slot_wnum[j*WNUM_W +: WNUM_W];
      w_ent[j].wdata = XLEN_MAX'(w_slot_wdata[j*XLEN +: XLEN]);
      w_ent[j].seq   = SEQW_MAX'(r_next_seq + SEQW'(j));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_next_seq <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr   <= r_wr_ptr + PW'(w_k);
        r_next_seq <= r_next_seq + SEQW'(w_k);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level <= r_level + w_k_acc - LW'(w_deq);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage carries no reset; stale contents are masked by the empty check on the read side.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      for (int j = 0; j < NC; j++) begin
        if (CNT_W'(j) < w_k) begin
          r_mem[r_wr_ptr + PW'(j)] <= w_ent[j];
        end
      end
    end
  end

  always_comb begin
    w_head         = r_mem[r_rd_ptr];
    bus.out_valid  = w_valid;
    bus.out_pc     = w_valid ? w_head.pc[XLEN-1:0]    : '0;
    bus.out_wnum   = w_valid ? w_head.wnum            : '0;
    bus.out_wdata  = w_valid ? w_head.wdata[XLEN-1:0] : '0;
    bus.out_seq    = w_valid ? w_head.seq[SEQW-1:0]   : '0;
    bus.level      = r_level;
    bus.overflow   = r_overflow;
    bus.core_stall = (w_free < LW'(NC));
  end
endmodule

// File: tb/tb_commit_trace_queue.sv
// Bench for commit_trace_queue: NC=2, DEPTH=16, SEQW=4 so sequence wrap is reachable.
// Scoreboard of expected entries plus a table of compaction/x0 vectors.
module tb_commit_trace_queue;
  import trace_pkg::*;

  localparam int NC    = 2;
  localparam int DEPTH = 16;
  localparam int XLEN  = 64;
  localparam int SEQW  = 4;
  localparam int LW    = 5;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  commit_trace_queue_if #(.NC(NC), .XLEN(XLEN), .SEQW(SEQW), .LW(LW)) bus ();

  commit_trace_queue #(.NC(NC), .DEPTH(DEPTH), .XLEN(XLEN), .SEQW(SEQW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [3:0]  seq;
  } exp_t;

  typedef struct {
    logic [1:0]  c;
    logic [4:0]  w0, w1;
    logic [63:0] d0, d1;
    int          exp_lvl;
    logic [4:0]  exp_wnum;
    logic [63:0] exp_wdata;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];
  int         lvl_m;
  logic       ovf_m;
  logic [3:0] seq_m;
  vec_t       vt[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One clock: present inputs, check the head against the scoreboard, advance the model.
  task automatic cycle(input logic [1:0] c, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic [4:0] w0, input logic [4:0] w1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic rdy);
    int   k;
    int   free;
    logic deq_m;
    exp_t e;
    bus.in_commit = c;
    bus.in_pc     = {pc1, pc0};
    bus.in_wnum   = {w1, w0};
    bus.in_wdata  = {d1, d0};
    bus.out_ready = rdy;
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
    deq_m = (sb.size() != 0) && rdy;
    if (deq_m) begin
      e = sb.pop_front();
      chk("out_pc", bus.out_pc, e.pc);
      chk("out_wnum", 64'(bus.out_wnum), 64'(e.wnum));
      chk("out_wdata", bus.out_wdata, e.wdata);
      chk("out_seq", 64'(bus.out_seq), 64'(e.seq));
    end
    k    = int'(c[0]) + int'(c[1]);
    free = DEPTH - lvl_m;
    if (k > 0 && k <= free) begin
      if (c[0]) begin
        e.pc = pc0; e.wnum = w0; e.wdata = (w0 == 5'd0) ? 64'd0 : d0; e.seq = seq_m;
        sb.push_back(e); seq_m = seq_m + 4'd1;
      end
      if (c[1]) begin
        e.pc = pc1; e.wnum = w1; e.wdata = (w1 == 5'd0) ? 64'd0 : d1; e.seq = seq_m;
        sb.push_back(e); seq_m = seq_m + 4'd1;
      end
      lvl_m = lvl_m + k;
    end else if (k > free) begin
      ovf_m = 1'b1;
    end
    if (deq_m) lvl_m = lvl_m - 1;
    @(posedge clock);
    #1;
    chk("level", 64'(bus.level), 64'(lvl_m));
    chk("overflow", 64'(bus.overflow), 64'(ovf_m));
    chk("core_stall", 64'(bus.core_stall), 64'((DEPTH - lvl_m) < NC));
  endtask

  task automatic idle(input logic rdy);
    cycle(2'b00, 64'd0, 64'd0, 5'd0, 5'd0, 64'd0, 64'd0, rdy);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      idle(1'b1);
      n++;
    end
    chk("drain_done", 64'(sb.size()), 64'd0);
  endtask

  // Asserts reset away from the clock edge and checks the asynchronous clear at once.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    sb.delete();
    lvl_m = 0;
    ovf_m = 1'b0;
    seq_m = 4'd0;
    bus.in_commit = '0;
    bus.out_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         sent;
    logic       rdy;
    logic [1:0] c;
    reset_n       = 1'b1;
    bus.in_commit = '0;
    bus.in_pc     = '0;
    bus.in_wnum   = '0;
    bus.in_wdata  = '0;
    bus.out_ready = 1'b0;
    lvl_m = 0; ovf_m = 1'b0; seq_m = 4'd0;
    #2;
    do_reset();
    chk("rst_core_stall", 64'(bus.core_stall), 64'd0);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    chk("rst_out_pc", bus.out_pc, 64'd0);
    chk("rst_out_seq", 64'(bus.out_seq), 64'd0);

    vt[0] = '{c: 2'b10, w0: 5'd3, w1: 5'd5, d0: 64'h1111, d1: 64'hDEAD,
              exp_lvl: 1, exp_wnum: 5'd5, exp_wdata: 64'hDEAD};
    vt[1] = '{c: 2'b01, w0: 5'd0, w1: 5'd9, d0: 64'h1234, d1: 64'h9999,
              exp_lvl: 1, exp_wnum: 5'd0, exp_wdata: 64'h0};
    vt[2] = '{c: 2'b11, w0: 5'd7, w1: 5'd0, d0: 64'hBEEF, d1: 64'h55,
              exp_lvl: 2, exp_wnum: 5'd7, exp_wdata: 64'hBEEF};
    vt[3] = '{c: 2'b00, w0: 5'd1, w1: 5'd2, d0: 64'hAAAA, d1: 64'hBBBB,
              exp_lvl: 0, exp_wnum: 5'd0, exp_wdata: 64'h0};
    for (int v = 0; v < 4; v++) begin
      do_reset();
      cycle(vt[v].c, 64'h100, 64'h104, vt[v].w0, vt[v].w1, vt[v].d0, vt[v].d1, 1'b0);
      chk($sformatf("vec%0d_level", v), 64'(bus.level), 64'(vt[v].exp_lvl));
      chk($sformatf("vec%0d_wnum", v), 64'(bus.out_wnum), 64'(vt[v].exp_wnum));
      chk($sformatf("vec%0d_wdata", v), bus.out_wdata, vt[v].exp_wdata);
      chk($sformatf("vec%0d_seq", v), 64'(bus.out_seq), 64'd0);
      drain();
    end

    // Two-lane group, drained back to back with no write-to-read bypass.
    do_reset();
    cycle(2'b11, 64'h8000_0000, 64'h8000_0004, 5'd1, 5'd2, 64'h11, 64'h22, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("basic_empty", 64'(bus.out_valid), 64'd0);

    // Fill with the consumer stalled: stall appears only once free < NC.
    do_reset();
    for (int g = 0; g < 8; g++) begin
      cycle(2'b11, 64'h1000 + 64'(g * 8), 64'h1004 + 64'(g * 8), 5'd3, 5'd4,
            64'(g), 64'(g + 100), 1'b0);
      chk("bp_head_held", bus.out_pc, 64'h1000);
      if (g == 6) chk("bp_stall_at14", 64'(bus.core_stall), 64'd0);
    end
    chk("bp_stall_full", 64'(bus.core_stall), 64'd1);
    drain();

    // Overflow at level 15 with a same-cycle dequeue that must not be credited.
    do_reset();
    for (int g = 0; g < 7; g++) begin
      cycle(2'b11, 64'h2000 + 64'(g * 8), 64'h2004 + 64'(g * 8), 5'd6, 5'd7,
            64'(g), 64'(g), 1'b0);
    end
    cycle(2'b01, 64'h2100, 64'd0, 5'd8, 5'd0, 64'h77, 64'd0, 1'b0);
    chk("ovf_pre_level", 64'(bus.level), 64'd15);
    cycle(2'b11, 64'h2200, 64'h2204, 5'd9, 5'd10, 64'h1, 64'h2, 1'b1);
    chk("ovf_set", 64'(bus.overflow), 64'd1);
    chk("ovf_level", 64'(bus.level), 64'd14);
    cycle(2'b01, 64'h2300, 64'd0, 5'd11, 5'd0, 64'h3, 64'd0, 1'b1);
    drain();
    chk("ovf_sticky", 64'(bus.overflow), 64'd1);

    // Long stream: sequence numbers and pointers wrap several times.
    do_reset();
    sent = 0;
    for (int i = 0; i < 300 && sent < 40; i++) begin
      rdy = ((i % 4) != 0);
      c   = (lvl_m < DEPTH - 1) ? 2'b01 : 2'b00;
      cycle(c, 64'(sent) * 4, 64'd0, 5'((sent % 31) + 1), 5'd0, 64'(sent) << 8, 64'd0, rdy);
      if (c != 2'b00) sent++;
    end
    chk("wrap_sent", 64'(sent), 64'd40);
    cycle(2'b01, 64'hF00, 64'd0, 5'd2, 5'd0, 64'h5, 64'd0, 1'b0);
    cycle(2'b01, 64'hF04, 64'd0, 5'd3, 5'd0, 64'h6, 64'd0, 1'b0);
    chk("wrap_nonempty", 64'(bus.out_valid), 64'd1);
    do_reset();
    chk("post_rst_overflow", 64'(bus.overflow), 64'd0);
    cycle(2'b01, 64'hABC0, 64'd0, 5'd4, 5'd0, 64'h9, 64'd0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
